// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD adder control automaton.
// Digit sums are one bit wider than a BCD digit so the carry-out is visible.
package bcd_ctrl_pkg;

    localparam int BCD_DIGIT_W     = 4;
    localparam int BCD_CORR_THRESH = 10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_W,
        S_SUM,
        S_SUM_W,
        S_CHECK,
        S_INC_C,
        S_INC_C_W,
        S_PLUS6,
        S_PLUS6_W,
        S_INC_S,
        S_INC_S_W,
        S_DONE
    } ctrl_state_t;

    // True for both binary overflow (>=16) and the non-decimal range 10..15.
    function automatic logic needs_correction(input logic [BCD_DIGIT_W:0] digit_sum);
        return digit_sum >= (BCD_DIGIT_W + 1)'(BCD_CORR_THRESH);
    endfunction

endpackage

// File: rtl/bcd_add_control.sv
// Moore control FSM sequencing the n-digit BCD adder datapath: load, per-digit
// add, optional +6 correction, digit advance. Every pulse state has a settle state.
module bcd_add_control
    import bcd_ctrl_pkg::*;
#(
    parameter int N   = 5,
    parameter int S_W = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [S_W-1:0]                      s_in,
    input  logic [N-1:0][BCD_DIGIT_W:0]         C_in,
    output logic                                state_load,
    output logic                                state_sum,
    output logic                                state_inc_c,
    output logic                                state_plus_6_c,
    output logic                                state_inc_s,
    output logic                                busy,
    output logic                                done
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic                 s_done;
    logic [BCD_DIGIT_W:0] cur_digit;
    logic                 corr;

    assign s_done = (s_in >= S_W'(N));

    // Digit s is processed from the most significant storage slot downwards.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < N; i++) begin
            if (s_in == S_W'(N - 1 - i)) begin
                cur_digit = C_in[i];
            end
        end
    end

    assign corr = !s_done && needs_correction(cur_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = S_IDLE;
        state_load     = 1'b0;
        state_sum      = 1'b0;
        state_inc_c    = 1'b0;
        state_plus_6_c = 1'b0;
        state_inc_s    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = start ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                state_load = 1'b1;
                busy       = 1'b1;
                state_d    = S_LOAD_W;
            end
            S_LOAD_W: begin
                busy    = 1'b1;
                state_d = s_done ? S_DONE : S_SUM;
            end
            S_SUM: begin
                state_sum = 1'b1;
                busy      = 1'b1;
                state_d   = S_SUM_W;
            end
            S_SUM_W: begin
                busy    = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_d = corr ? S_INC_C : S_INC_S;
            end
            S_INC_C: begin
                state_inc_c = 1'b1;
                busy        = 1'b1;
                state_d     = S_INC_C_W;
            end
            S_INC_C_W: begin
                busy    = 1'b1;
                state_d = S_PLUS6;
            end
            S_PLUS6: begin
                state_plus_6_c = 1'b1;
                busy           = 1'b1;
                state_d        = S_PLUS6_W;
            end
            S_PLUS6_W: begin
                busy    = 1'b1;
                state_d = S_INC_S;
            end
            S_INC_S: begin
                state_inc_s = 1'b1;
                busy        = 1'b1;
                state_d     = S_INC_S_W;
            end
            S_INC_S_W: begin
                busy    = 1'b1;
                state_d = s_done ? S_DONE : S_SUM;
            end
            S_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_add_control.sv
// Scoreboard bench for bcd_add_control with a behavioural datapath counter model.
module tb_bcd_add_control;

    localparam int N   = 5;
    localparam int S_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [S_W-1:0]       s_in;
    logic [N-1:0][4:0]    C_in = '0;
    logic                 state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s;
    logic                 busy, done;
    logic                 skip_mode = 1'b0;

    always #5 clk = ~clk;

    bcd_add_control #(.N(N), .S_W(S_W)) dut (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in), .C_in(C_in),
        .state_load(state_load), .state_sum(state_sum), .state_inc_c(state_inc_c),
        .state_plus_6_c(state_plus_6_c), .state_inc_s(state_inc_s),
        .busy(busy), .done(done)
    );

    // Datapath digit counter: cleared by load (or parked at N), bumped by inc_s.
    always @(posedge clk) begin
        if (rst)              s_in <= '0;
        else if (state_load)  s_in <= skip_mode ? S_W'(N) : '0;
        else if (state_inc_s) s_in <= s_in + 1'b1;
    end

    typedef struct {
        int lat;
        int n_sum;
        int n_incs;
        int n_incc;
        int n_p6;
        int cmask;
        int pmask;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   load_count = 0;
    int   load_gap = -1;
    int   last_done_cyc = -100;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: each digit costs 5 cycles, 9 when its sum is 10 or more.
    function automatic exp_t model(input logic [N-1:0][4:0] c, input bit skip);
        exp_t e;
        int   digit;
        e = '{default: 0};
        e.lat = 2;
        if (!skip) begin
            for (int k = 0; k < N; k++) begin
                digit = int'(c[N-1-k]);
                e.n_sum++;
                e.n_incs++;
                if (digit >= 10) begin
                    e.lat   += 9;
                    e.n_incc++;
                    e.n_p6++;
                    e.cmask |= (1 << k);
                end else begin
                    e.lat += 5;
                end
            end
        end
        e.pmask = e.cmask;
        return e;
    endfunction

    task automatic monitor_loop();
        int in_op = 0, load_cyc = 0;
        int n_sum = 0, n_incs = 0, n_incc = 0, n_p6 = 0, cmask = 0, pmask = 0;
        logic [5:0] cur, prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_op = 0;
                prev  = '0;
                continue;
            end
            cur = {state_load, state_sum, state_inc_c, state_plus_6_c, state_inc_s, done};
            if (cur != '0) begin
                chk("pulse_onehot", $countones(cur), 1);
                chk("pulse_width", int'(|(cur & prev)), 0);
                chk("busy_with_pulse", int'(busy), 1);
            end
            prev = cur;
            if (state_load) begin
                load_count++;
                load_gap = cyc - last_done_cyc;
                in_op = 1; load_cyc = cyc;
                n_sum = 0; n_incs = 0; n_incc = 0; n_p6 = 0; cmask = 0; pmask = 0;
            end
            if (state_sum)      n_sum++;
            if (state_inc_s)    n_incs++;
            if (state_inc_c)    begin n_incc++; cmask |= (1 << s_in); end
            if (state_plus_6_c) begin n_p6++;   pmask |= (1 << s_in); end
            if (done) begin
                last_done_cyc = cyc;
                done_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_after_load", in_op, 1);
                    chk("latency", cyc - load_cyc, e.lat);
                    chk("sum_pulses", n_sum, e.n_sum);
                    chk("inc_s_pulses", n_incs, e.n_incs);
                    chk("inc_c_pulses", n_incc, e.n_incc);
                    chk("plus6_pulses", n_p6, e.n_p6);
                    chk("inc_c_digits", cmask, e.cmask);
                    chk("plus6_digits", pmask, e.pmask);
                end
                in_op = 0;
            end
        end
    endtask

    task automatic run_op(input logic [N-1:0][4:0] c, input bit skip, input bit toggle);
        int d0;
        bit got;
        @(posedge clk); #1;
        C_in      = c;
        skip_mode = skip;
        sb.push_back(model(c, skip));
        d0    = done_count;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_count > d0) begin got = 1; break; end
            @(posedge clk); #1;
            if (toggle && busy && !done) start = 1'($urandom_range(0, 1));
            else                         start = 1'b0;
        end
        start = 1'b0;
        if (!got) chk("op_timeout", 0, 1);
    endtask

    function automatic logic [N-1:0][4:0] fill(input int v);
        logic [N-1:0][4:0] c;
        for (int i = 0; i < N; i++) c[i] = 5'(v);
        return c;
    endfunction

    initial begin
        logic [N-1:0][4:0] c;
        int l0, d0;
        bit got;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({state_load, state_sum, state_inc_c, state_plus_6_c,
                                   state_inc_s, busy, done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_busy", int'(busy), 0);

        // No correction anywhere
        run_op(fill(4), 1'b0, 1'b0);

        // Single correction on the first digit processed
        c = fill(3); c[4] = 5'd12;
        run_op(c, 1'b0, 1'b0);

        // Threshold boundaries
        foreach (c[i]) c[i] = 5'd3;
        c[4] = 5'd9;  run_op(c, 1'b0, 1'b0);
        c[4] = 5'd10; run_op(c, 1'b0, 1'b0);
        c[4] = 5'd15; run_op(c, 1'b0, 1'b0);
        c[4] = 5'd16; run_op(c, 1'b0, 1'b0);
        c = fill(3); c[0] = 5'd10; c[2] = 5'd19;
        run_op(c, 1'b0, 1'b0);

        // Start held high across two operations
        @(posedge clk); #1;
        C_in = fill(3); skip_mode = 1'b0;
        sb.push_back(model(fill(3), 1'b0));
        sb.push_back(model(fill(3), 1'b0));
        l0 = load_count; d0 = done_count;
        start = 1'b1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (load_count >= l0 + 2) begin got = 1; break; end
        end
        start = 1'b0;
        chk("held_start_second_load", int'(got), 1);
        chk("restart_gap", load_gap, 2);
        for (int i = 0; i < 200 && done_count < d0 + 2; i++) @(posedge clk);
        chk("held_start_done_count", done_count - d0, 2);

        // Counter already at N after load
        run_op(fill(12), 1'b1, 1'b0);

        // Asynchronous reset while in PLUS6
        @(posedge clk); #1;
        c = fill(3); c[4] = 5'd12;
        C_in = c; skip_mode = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !state_plus_6_c; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_plus6", int'(state_plus_6_c), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({state_load, state_sum, state_inc_c, state_plus_6_c,
                                         state_inc_s, busy, done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_reset_busy", int'(busy), 0);
        run_op(fill(4), 1'b0, 1'b0);

        // Randomized operations with start chatter while busy
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < N; i++) c[i] = 5'($urandom_range(0, 19));
            run_op(c, ($urandom_range(0, 7) == 0), 1'b1);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
